// File: rtl/pp_buf_pkg.sv
// ============================================================================
// Module      : pp_buf_pkg
// Description : Shared constants and index-width helper for the ping-pong
//               buffer family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pp_buf_pkg;

    localparam int c_NBUF_MIN = 2;
    localparam int c_NBUF_MAX = 16;

    // Buffer index width; never narrower than one bit.
    function automatic int pp_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_pingpong_buf_if.sv
// ============================================================================
// Module      : multi_pingpong_buf_if
// Description : Writer/reader/status bundle of the multi-buffer ping-pong.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multi_pingpong_buf_if
    import pp_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NBUF  = 2
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_IDX_W  = pp_idx_w(NBUF);
    localparam int c_FILL_W = $clog2(NBUF + 1);

    logic                wr_en;
    logic [c_ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic                wr_commit;
    logic                wr_ready;
    logic [c_IDX_W-1:0]  wr_buf_idx;
    logic                rd_en;
    logic [c_ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]    rd_data;
    logic                rd_release;
    logic                rd_valid;
    logic [c_IDX_W-1:0]  rd_buf_idx;
    logic [c_FILL_W-1:0] fill_cnt;
    logic                err_clr;
    logic                err_ovf;
    logic                err_udf;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release, err_clr,
        input  wr_ready, wr_buf_idx, rd_data, rd_valid, rd_buf_idx, fill_cnt, err_ovf, err_udf
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release, err_clr,
        output wr_ready, wr_buf_idx, rd_data, rd_valid, rd_buf_idx, fill_cnt, err_ovf, err_udf
    );

endinterface

`default_nettype wire

// File: rtl/ad_mem.sv
// ============================================================================
// Module      : ad_mem
// Description : Simple dual-port RAM, port A write, port B registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     i_wea,
    input  wire logic [$clog2(DEPTH)-1:0] i_addra,
    input  wire logic [WIDTH-1:0]         i_dina,
    input  wire logic                     i_reb,
    input  wire logic [$clog2(DEPTH)-1:0] i_addrb,
    output logic      [WIDTH-1:0]         o_doutb
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wea) begin
            r_mem[i_addra] <= i_dina;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reb) begin
            o_doutb <= r_mem[i_addrb];
        end
    end

endmodule

`default_nettype wire

// File: rtl/pp_ring_ctrl.sv
// ============================================================================
// Module      : pp_ring_ctrl
// Description : Ring ownership control: write/read pointers, fill count and
//               sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_ring_ctrl
    import pp_buf_pkg::*;
#(
    parameter int NBUF = 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_wr_commit,
    input  wire logic                         i_rd_release,
    input  wire logic                         i_err_clr,
    output logic      [pp_idx_w(NBUF)-1:0]    o_wr_ptr,
    output logic      [pp_idx_w(NBUF)-1:0]    o_rd_ptr,
    output logic      [$clog2(NBUF+1)-1:0]    o_fill,
    output logic                              o_wr_ready,
    output logic                              o_rd_valid,
    output logic                              o_err_ovf,
    output logic                              o_err_udf
);

    localparam int c_IDX_W  = pp_idx_w(NBUF);
    localparam int c_FILL_W = $clog2(NBUF + 1);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NBUF - 1);

    if (NBUF < c_NBUF_MIN || NBUF > c_NBUF_MAX) begin : g_bad_nbuf
        $error("pp_ring_ctrl: NBUF out of range");
    end

    logic [c_IDX_W-1:0]  r_wr_ptr;
    logic [c_IDX_W-1:0]  r_rd_ptr;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_err_ovf;
    logic                r_err_udf;
    logic                w_commit_ok;
    logic                w_release_ok;

    assign o_wr_ready   = (r_fill < c_FILL_W'(NBUF));
    assign o_rd_valid   = (r_fill != '0);
    assign w_commit_ok  = i_wr_commit  & o_wr_ready;
    assign w_release_ok = i_rd_release & o_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_commit_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_IDX_W'(1);
            end
            if (w_release_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_IDX_W'(1);
            end
            unique case ({w_commit_ok, w_release_ok})
                2'b10:   r_fill <= r_fill + c_FILL_W'(1);
                2'b01:   r_fill <= r_fill - c_FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
            // A fresh error wins over a clear in the same cycle.
            if (i_wr_commit && !o_wr_ready) begin
                r_err_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_err_ovf <= 1'b0;
            end
            if (i_rd_release && !o_rd_valid) begin
                r_err_udf <= 1'b1;
            end else if (i_err_clr) begin
                r_err_udf <= 1'b0;
            end
        end
    end

    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_fill    = r_fill;
    assign o_err_ovf = r_err_ovf;
    assign o_err_udf = r_err_udf;

endmodule

`default_nettype wire

// File: rtl/multi_pingpong_buf.sv
// ============================================================================
// Module      : multi_pingpong_buf
// Description : N-bank ping-pong buffer; writer fills and commits banks,
//               reader drains and releases them in ring order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_pingpong_buf
    import pp_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NBUF  = 2
) (
    input wire logic             clk,
    input wire logic             rst,
    multi_pingpong_buf_if.slave  bus
);

    localparam int c_IDX_W = pp_idx_w(NBUF);

    logic [c_IDX_W-1:0] w_wr_ptr;
    logic [c_IDX_W-1:0] w_rd_ptr;
    logic               w_wr_ready;
    logic [WIDTH-1:0]   w_bank_dout [NBUF];
    logic [c_IDX_W-1:0] r_rd_sel;
    logic               r_rd_seen;

    pp_ring_ctrl #(.NBUF(NBUF)) u_ring (
        .clk          (clk),
        .rst          (rst),
        .i_wr_commit  (bus.wr_commit),
        .i_rd_release (bus.rd_release),
        .i_err_clr    (bus.err_clr),
        .o_wr_ptr     (w_wr_ptr),
        .o_rd_ptr     (w_rd_ptr),
        .o_fill       (bus.fill_cnt),
        .o_wr_ready   (w_wr_ready),
        .o_rd_valid   (bus.rd_valid),
        .o_err_ovf    (bus.err_ovf),
        .o_err_udf    (bus.err_udf)
    );

    for (genvar b = 0; b < NBUF; b++) begin : g_bank
        ad_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
            .clk     (clk),
            .i_wea   (bus.wr_en && w_wr_ready && (w_wr_ptr == c_IDX_W'(b))),
            .i_addra (bus.wr_addr),
            .i_dina  (bus.wr_data),
            .i_reb   (bus.rd_en),
            .i_addrb (bus.rd_addr),
            .o_doutb (w_bank_dout[b])
        );
    end

    // Bank select is latched with rd_en so a same-cycle release cannot
    // redirect the data; r_rd_seen masks unreset RAM outputs after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_sel  <= '0;
            r_rd_seen <= 1'b0;
        end else if (bus.rd_en) begin
            r_rd_sel  <= w_rd_ptr;
            r_rd_seen <= 1'b1;
        end
    end

    assign bus.rd_data    = r_rd_seen ? w_bank_dout[r_rd_sel] : '0;
    assign bus.wr_ready   = w_wr_ready;
    assign bus.wr_buf_idx = w_wr_ptr;
    assign bus.rd_buf_idx = w_rd_ptr;

endmodule

`default_nettype wire

// File: tb/tb_multi_pingpong_buf.sv
// ============================================================================
// Module      : tb_multi_pingpong_buf
// Description : Directed vector bench for multi_pingpong_buf (NBUF=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_pingpong_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multi_pingpong_buf_if #(.WIDTH(8), .DEPTH(16), .NBUF(3)) bus ();

    multi_pingpong_buf #(.WIDTH(8), .DEPTH(16), .NBUF(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       nm;
        logic        we;
        logic [3:0]  wa;
        logic [7:0]  wd;
        logic        wc;
        logic        re;
        logic [3:0]  ra;
        logic        rr;
        logic        ec;
        logic [17:0] expv;
        logic        dchk;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Packed expectation: {wr_ready, rd_valid, wr_idx, rd_idx, fill, ovf, udf, rd_data}
    function automatic logic [17:0] ex(logic rdy, logic vld, logic [1:0] wi, logic [1:0] ri,
                                       logic [1:0] f, logic ov, logic ud, logic [7:0] d);
        return {rdy, vld, wi, ri, f, ov, ud, d};
    endfunction

    function automatic vec_t mk(string nm, logic we, logic [3:0] wa, logic [7:0] wd, logic wc,
                                logic re, logic [3:0] ra, logic rr, logic ec, logic [17:0] e);
        vec_t v;
        v.nm = nm; v.we = we; v.wa = wa; v.wd = wd; v.wc = wc;
        v.re = re; v.ra = ra; v.rr = rr; v.ec = ec; v.expv = e; v.dchk = 1'b1;
        return v;
    endfunction

    task automatic check(string nm, logic [17:0] e, logic dchk);
        logic [17:0] obs;
        logic [17:0] mask;
        obs  = {bus.wr_ready, bus.rd_valid, bus.wr_buf_idx, bus.rd_buf_idx, bus.fill_cnt,
                bus.err_ovf, bus.err_udf, bus.rd_data};
        mask = dchk ? 18'h3FFFF : 18'h3FF00;
        n_vec++;
        if ((obs & mask) !== (e & mask)) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (rdy,vld,wi,ri,fill,ovf,udf,data)", nm, obs, e);
        end
    endtask

    task automatic drive(logic we, logic [3:0] wa, logic [7:0] wd, logic wc,
                         logic re, logic [3:0] ra, logic rr, logic ec);
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_commit = wc;
        bus.rd_en = re; bus.rd_addr = ra; bus.rd_release = rr; bus.err_clr = ec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] wi;
        logic [1:0] ri;

        // Fill buffer 0 with 0x10+i, commit, read it back.
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk("wr_b0", 1, 4'(i), 8'(8'h10 + i), 0, 0, 0, 0, 0, ex(1,0,0,0,0,0,0,8'h00)));
        tbl.push_back(mk("commit_b0", 0, 0, 0, 1, 0, 0, 0, 0, ex(1,1,1,0,1,0,0,8'h00)));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk("rd_b0", 0, 0, 0, 0, 1, 4'(i), 0, 0, ex(1,1,1,0,1,0,0,8'(8'h10 + i))));
        // Fill to full, overflow, dropped write.
        tbl.push_back(mk("wr_b1",       1, 5, 8'hA5, 0, 0, 0, 0, 0, ex(1,1,1,0,1,0,0,8'h1F)));
        tbl.push_back(mk("commit_b1",   0, 0, 0,     1, 0, 0, 0, 0, ex(1,1,2,0,2,0,0,8'h1F)));
        tbl.push_back(mk("wr_b2",       1, 5, 8'hB5, 0, 0, 0, 0, 0, ex(1,1,2,0,2,0,0,8'h1F)));
        tbl.push_back(mk("commit_full", 0, 0, 0,     1, 0, 0, 0, 0, ex(0,1,0,0,3,0,0,8'h1F)));
        tbl.push_back(mk("commit_ovf",  0, 0, 0,     1, 0, 0, 0, 0, ex(0,1,0,0,3,1,0,8'h1F)));
        tbl.push_back(mk("wr_dropped",  1, 0, 8'hEE, 0, 0, 0, 0, 0, ex(0,1,0,0,3,1,0,8'h1F)));
        // Drain, including read+release on buffer 1.
        tbl.push_back(mk("release_b0",  0, 0, 0, 0, 0, 0, 1, 0, ex(1,1,0,1,2,1,0,8'h1F)));
        tbl.push_back(mk("rd_rel_b1",   0, 0, 0, 0, 1, 5, 1, 0, ex(1,1,0,2,1,1,0,8'hA5)));
        tbl.push_back(mk("rd_b2",       0, 0, 0, 0, 1, 5, 0, 0, ex(1,1,0,2,1,1,0,8'hB5)));
        tbl.push_back(mk("release_b2",  0, 0, 0, 0, 0, 0, 1, 0, ex(1,0,0,0,0,1,0,8'hB5)));
        // Underflow and flag clearing.
        tbl.push_back(mk("release_udf", 0, 0, 0, 0, 0, 0, 1, 0, ex(1,0,0,0,0,1,1,8'hB5)));
        tbl.push_back(mk("err_clr",     0, 0, 0, 0, 0, 0, 0, 1, ex(1,0,0,0,0,0,0,8'hB5)));
        tbl.push_back(mk("udf_vs_clr",  0, 0, 0, 0, 0, 0, 1, 1, ex(1,0,0,0,0,0,1,8'hB5)));
        tbl.push_back(mk("err_clr2",    0, 0, 0, 0, 0, 0, 0, 1, ex(1,0,0,0,0,0,0,8'hB5)));
        // Write+commit same cycle lands in buffer 0; earlier dropped write left 0x10.
        tbl.push_back(mk("wr_commit",   1, 1, 8'h77, 1, 0, 0, 0, 0, ex(1,1,1,0,1,0,0,8'hB5)));
        tbl.push_back(mk("rd_b0_a0",    0, 0, 0, 0, 1, 0, 0, 0, ex(1,1,1,0,1,0,0,8'h10)));
        tbl.push_back(mk("rd_b0_a1",    0, 0, 0, 0, 1, 1, 0, 0, ex(1,1,1,0,1,0,0,8'h77)));
        tbl.push_back(mk("hold",        0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,1,0,1,0,0,8'h77)));
        // Commit+release together four times: both indices advance and wrap.
        wi = 2'd1; ri = 2'd0;
        for (int k = 0; k < 4; k++) begin
            wi = (wi == 2'd2) ? 2'd0 : wi + 2'd1;
            ri = (ri == 2'd2) ? 2'd0 : ri + 2'd1;
            tbl.push_back(mk("commit_rel", 0, 0, 0, 1, 0, 0, 1, 0, ex(1,1,wi,ri,1,0,0,8'h77)));
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("reset", ex(1,0,0,0,0,0,0,8'h00), 1'b1);
        rst = 1'b0;

        foreach (tbl[j]) begin
            drive(tbl[j].we, tbl[j].wa, tbl[j].wd, tbl[j].wc,
                  tbl[j].re, tbl[j].ra, tbl[j].rr, tbl[j].ec);
            step();
            check(tbl[j].nm, tbl[j].expv, tbl[j].dchk);
        end

        // Reach fill=2 with a read pending, then reset mid-cycle.
        drive(0, 0, 0, 1, 1, 5, 0, 0);
        step();
        check("pre_rst_fill2", ex(1,1,0,1,2,0,0,8'hA5), 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", ex(1,0,0,0,0,0,0,8'h00), 1'b1);
        step();
        check("rst_held", ex(1,0,0,0,0,0,0,8'h00), 1'b1);
        rst = 1'b0;
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        step();
        check("post_rst_commit", ex(1,1,1,0,1,0,0,8'h00), 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_pingpong_buf.md
MULTI_PINGPONG_BUF -- requirements
Module: multi_pingpong_buf

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, words per buffer; ADDR_WIDTH = $clog2(DEPTH).
REQ-003 Parameter NBUF, default 2, number of buffers (banks); legal range 2..16.
REQ-004 Port clk, input, 1: single clock for all logic and memories.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port wr_en, input, 1: write strobe into the current write buffer.
REQ-007 Port wr_addr, input, ADDR_WIDTH: word address within the write buffer.
REQ-008 Port wr_data, input, WIDTH: write data.
REQ-009 Port wr_commit, input, 1: pulse; the writer hands the current buffer to the reader.
REQ-010 Port wr_ready, output, 1: a free buffer is owned by the writer.
REQ-011 Port wr_buf_idx, output, $clog2(NBUF): index of the current write buffer.
REQ-012 Port rd_en, input, 1: read strobe from the current read buffer.
REQ-013 Port rd_addr, input, ADDR_WIDTH: word address within the read buffer.
REQ-014 Port rd_data, output, WIDTH: registered read data.
REQ-015 Port rd_release, input, 1: pulse; the reader returns the current buffer to the free pool.
REQ-016 Port rd_valid, output, 1: at least one committed buffer is available to the reader.
REQ-017 Port rd_buf_idx, output, $clog2(NBUF): index of the current read buffer.
REQ-018 Port fill_cnt, output, $clog2(NBUF+1): number of committed, unreleased buffers.
REQ-019 Port err_clr, input, 1: clears the sticky error flags.
REQ-020 Port err_ovf / err_udf, output, 1 each: sticky commit-when-full and release-when-empty flags.

Function
REQ-021 The block SHALL manage the buffers as a ring: wr_ptr, rd_ptr in 0..NBUF-1, fill in 0..NBUF; wr_buf_idx=wr_ptr, rd_buf_idx=rd_ptr, fill_cnt=fill.
REQ-022 wr_ready SHALL equal (fill<NBUF); rd_valid SHALL equal (fill>0); both are combinational from registered state.
REQ-023 A write with wr_en=1 and wr_ready=1 SHALL store wr_data at wr_addr of buffer wr_ptr at the clock edge; with wr_ready=0 it SHALL be dropped.
REQ-024 An accepted wr_commit (wr_ready=1) SHALL advance wr_ptr by 1, wrapping NBUF-1 to 0, and increment fill.
REQ-025 An accepted rd_release (rd_valid=1) SHALL advance rd_ptr by 1, wrapping NBUF-1 to 0, and decrement fill.
REQ-026 Simultaneous accepted commit and release SHALL move both pointers and leave fill unchanged.
REQ-027 A write and a commit in the same cycle SHALL land in the pre-commit buffer.
REQ-028 rd_data SHALL appear one cycle after rd_en=1, from the buffer selected by rd_ptr in the rd_en cycle, even if rd_release occurs in that cycle; rd_data SHALL hold when rd_en=0.
REQ-029 rd_en while rd_valid=0 SHALL still read buffer rd_ptr; the data is undefined and not an error.
REQ-030 wr_commit with wr_ready=0 SHALL be ignored and SHALL set err_ovf; rd_release with rd_valid=0 SHALL be ignored and SHALL set err_udf.
REQ-031 err_clr SHALL clear both flags next cycle; a new error in the same cycle takes priority and sets the flag.
REQ-032 Writer and reader SHALL never own the same buffer while fill is between 1 and NBUF-1.

Reset
REQ-033 Asserting rst SHALL immediately force wr_ptr=0, rd_ptr=0, fill=0, rd_data=0, err_ovf=0, err_udf=0, giving wr_ready=1 and rd_valid=0.
REQ-034 Buffer memory contents are not reset; reset mid-operation discards all committed buffers.

Structure
REQ-035 Memory SHALL be NBUF instances of the team dual-port RAM ad_mem (generate loop), port A write-enabled only for bank wr_ptr, port B read with reb=rd_en.
REQ-036 The ring control (pointers, fill, flags) SHALL be one sub-module, pp_ring_ctrl, parametrised by NBUF.
REQ-037 The index-width function and the NBUF range limits SHALL live in a shared package, pp_buf_pkg.

Verification (WIDTH=8, DEPTH=16, NBUF=3)
REQ-038 Reset, then write 0x10+i at addr i (i=0..15), commit, 16 reads -> rd_valid=1, rd_buf_idx=0, rd_data=0x10+i one cycle after each rd_en.
REQ-039 Three commits without release -> fill_cnt=3, wr_ready=0; a fourth commit -> err_ovf=1, wr_buf_idx unchanged at 0; a write is dropped.
REQ-040 Release with fill=0 -> err_udf=1, rd_buf_idx stays 0; err_clr -> both flags 0 next cycle.
REQ-041 fill=1, commit and release in the same cycle -> fill_cnt stays 1, wr_buf_idx and rd_buf_idx each advance by 1; repeating 4 times wraps both indices 2->0.
REQ-042 rd_en and rd_release in the same cycle on buffer 1 -> rd_data comes from buffer 1, next rd_buf_idx=2.
REQ-043 rst asserted mid-stream with fill=2 -> outputs return to reset values asynchronously, before the next clk edge.
